mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single 256-bit off-chip data-memory port. Sits between the CPU-side caches (requester 0 = data cache, requester 1 = instruction-cache refill) and the Data_Memory model. It grants one line transfer at a time using round-robin priority, drives the memory enable/write/address/data lines from registers, and returns `mem_ack_i` and read data only to the granted requester. A watchdog aborts a transfer whose acknowledge never arrives.

## Interface
- ADDR_W, 32, address width
- DATA_W, 256, line width
- TIMEOUT, 1023, max cycles in BUSY before abort; 0 disables watchdog (max 65535)

- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-low
- m0_enable_i / m1_enable_i  in  1  request; held until ack
- m0_write_i / m1_write_i  in  1  1 = write line, 0 = read line
- m0_addr_i / m1_addr_i  in  ADDR_W  line address
- m0_data_i / m1_data_i  in  DATA_W  write data
- m0_data_o / m1_data_o  out  DATA_W  read data, valid only with ack
- m0_ack_o / m1_ack_o  out  1  one-cycle completion pulse
- mem_data_i  in  DATA_W  memory read data
- mem_ack_i  in  1  memory completion pulse
- mem_data_o  out  DATA_W  registered write data
- mem_addr_o  out  ADDR_W  registered address
- mem_enable_o  out  1  registered request to memory
- mem_write_o  out  1  registered write strobe
- grant_o  out  1  index of current/last granted requester
- busy_o  out  1  1 while in BUSY
- err_o  out  1  sticky watchdog abort flag

## Operation
- States: IDLE, BUSY, GAP.
- IDLE: no requests -> stay. One request -> grant it. Both requests -> grant the requester that is not `last_grant`.
  - On grant, register the granted address, data and write into `mem_*_o`. Set `mem_enable_o=1` and `last_grant`, and go to BUSY.
- BUSY: `mem_enable_o` is held and the latched fields are frozen. Requester input changes, including enable dropping, are ignored.
  - On `mem_ack_i=1`:
    - The granted requester's `mX_ack_o` = 1 in the same cycle (combinational).
    - `mX_data_o` = `mem_data_i`.
    - Go to GAP.
- GAP: exactly one cycle, `mem_enable_o=0`. This lets the acked requester drop its enable before re-arbitration. Then go to IDLE.
- Watchdog, when TIMEOUT≠0:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT: pulse the granted `mX_ack_o` with `mX_data_o=0`, set `err_o=1`, go to GAP.
  - An ack in the same cycle as the timeout wins: normal completion, no error.
- Ack routing:
  - A non-granted requester always sees `ack_o=0`.
  - `mX_data_o` is 0 whenever that requester's `ack_o=0`.
  - `mem_ack_i` in IDLE or GAP is a stray ack and is ignored; no output changes.
- Reset (rst_i=0 at a clock edge), from any state including mid-BUSY:
  - state = IDLE, all `mem_*_o` = 0, `last_grant` = 1 (so requester 0 wins the first tie).
  - `grant_o` = 1, `busy_o` = 0, `err_o` = 0, watchdog counter = 0.
  - An in-flight transfer is dropped without ack.

## Timing
- Grant latency: request sampled in IDLE at edge t -> `mem_enable_o`=1 and `busy_o`=1 after edge t (visible in cycle t+1).
- Completion: `mem_ack_i` in cycle k -> `mX_ack_o` in cycle k -> `mem_enable_o`=0 in cycle k+1 (GAP) -> IDLE in cycle k+2.
  - Earliest next `mem_enable_o` is cycle k+3.
- Minimum back-to-back transfer overhead: 2 idle cycles on the memory port.
- Abort: a timeout ack occurs in the BUSY cycle in which the counter equals TIMEOUT, i.e. cycle TIMEOUT+1 after `mem_enable_o` rises.
- `mem_*_o`, `grant_o`, `busy_o` and `err_o` are registered.
- `mX_ack_o` and `mX_data_o` are combinational from `mem_ack_i`, `mem_data_i` and state.

## Test plan
- Single read by m0, addr 0x0000_0400, memory acks 10 cycles after enable with data 0xA5…A5:
  - `mem_enable_o`=1 with `mem_write_o`=0 and addr 0x400 one cycle after request.
  - `m0_ack_o`=1 with data 0xA5…A5 in the ack cycle; `m1_ack_o` stays 0.
- Both requesters assert in the same cycle after reset, m0 write and m1 read:
  - m0 granted first (`grant_o`=0), then m1 (`grant_o`=1).
  - A repeated simultaneous request then grants m0 again (alternation).
- m1 changes addr from 0x100 to 0x200 mid-BUSY: `mem_addr_o` stays 0x100 until the ack; ack is returned to m1.
- TIMEOUT=8, memory never acks:
  - `m0_ack_o` pulses with data 0 in the 9th cycle of enable.
  - `err_o`=1 and stays 1; the next request still completes normally.
- rst_i=0 during BUSY:
  - Next cycle: `mem_enable_o`=0, `busy_o`=0, `err_o`=0, `grant_o`=1.
  - A late `mem_ack_i` produces no `mX_ack_o`.
- Stray `mem_ack_i` in IDLE with no requests: both `mX_ack_o` stay 0 and the state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for the shared 256-bit data-memory port.
// One line transfer at a time, with a one-cycle gap after each and a watchdog abort.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic              grant_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_e;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                enable_q, enable_d;
  logic                err_q, err_d;
  logic [15:0]         wd_cnt_q, wd_cnt_d;

  logic any_req;
  logic pick;
  logic timeout_hit;
  logic done;

  // On a tie the requester that did not win last time gets the port.
  assign any_req     = m0_enable_i | m1_enable_i;
  assign pick        = (m0_enable_i && m1_enable_i) ? ~last_grant_q : m1_enable_i;
  assign timeout_hit = (TIMEOUT != 0) && (state_q == S_BUSY) && (wd_cnt_q == TIMEOUT_C);
  assign done        = (state_q == S_BUSY) && (mem_ack_i || timeout_hit);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_BUSY;
      S_BUSY:  if (done) state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m0_ack_o  = done && !last_grant_q;
    m1_ack_o  = done && last_grant_q;
    // A watchdog abort returns zero data; only a real ack carries memory data.
    m0_data_o = (m0_ack_o && mem_ack_i) ? mem_data_i : '0;
    m1_data_o = (m1_ack_o && mem_ack_i) ? mem_data_i : '0;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    enable_d     = enable_q;
    err_d        = err_q;
    wd_cnt_d     = wd_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          last_grant_d = pick;
          addr_d       = pick ? m1_addr_i  : m0_addr_i;
          wdata_d      = pick ? m1_data_i  : m0_data_i;
          write_d      = pick ? m1_write_i : m0_write_i;
          enable_d     = 1'b1;
          wd_cnt_d     = '0;
        end
      end
      S_BUSY: begin
        if (done) begin
          enable_d = 1'b0;
          if (!mem_ack_i) err_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      enable_q     <= 1'b0;
      err_q        <= 1'b0;
      wd_cnt_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      enable_q     <= enable_d;
      err_q        <= err_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  assign mem_addr_o   = addr_q;
  assign mem_data_o   = wdata_q;
  assign mem_write_o  = write_q;
  assign mem_enable_o = enable_q;
  assign grant_o      = last_grant_q;
  assign busy_o       = (state_q == S_BUSY);
  assign err_o        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed multi-cycle sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          m0_en, m0_wr, m1_en, m1_wr, mem_ack;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, mem_rdata;

  logic          d_ack0, d_ack1, d_men, d_mwr, d_grant, d_busy, d_err;
  logic [DW-1:0] d_d0, d_d1, d_mdata;
  logic [AW-1:0] d_maddr;
  logic          l_ack0, l_ack1, l_men, l_mwr, l_grant, l_busy, l_err;
  logic [DW-1:0] l_d0, l_d1, l_mdata;
  logic [AW-1:0] l_maddr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .m0_enable_i(m0_en), .m0_write_i(m0_wr), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
    .m0_data_o(d_d0), .m0_ack_o(d_ack0),
    .m1_enable_i(m1_en), .m1_write_i(m1_wr), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
    .m1_data_o(d_d1), .m1_ack_o(d_ack1),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack), .mem_data_o(d_mdata), .mem_addr_o(d_maddr),
    .mem_enable_o(d_men), .mem_write_o(d_mwr), .grant_o(d_grant), .busy_o(d_busy), .err_o(d_err)
  );

  // Second instance with the default watchdog, for the long-latency read.
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut_l (
    .clk_i(clk), .rst_i(rst_n),
    .m0_enable_i(m0_en), .m0_write_i(m0_wr), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
    .m0_data_o(l_d0), .m0_ack_o(l_ack0),
    .m1_enable_i(m1_en), .m1_write_i(m1_wr), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
    .m1_data_o(l_d1), .m1_ack_o(l_ack1),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack), .mem_data_o(l_mdata), .mem_addr_o(l_maddr),
    .mem_enable_o(l_men), .mem_write_o(l_mwr), .grant_o(l_grant), .busy_o(l_busy), .err_o(l_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [DW-1:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; m0_en = 1'b0; m1_en = 1'b0; mem_ack = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic rn; logic e0; logic w0; logic [AW-1:0] a0;
    logic e1; logic w1; logic [AW-1:0] a1; logic mack; logic [7:0] mb;
    logic x_a0; logic x_a1; logic x_en; logic x_wr; logic [AW-1:0] x_addr;
    logic x_g; logic x_b; logic x_err;
  } vec_t;

  vec_t tbl[20];

  // Reference model state for the random run.
  int            owner, age, pick;
  bit            cool, last, merr, lwr;
  logic [AW-1:0] laddr;
  logic [DW-1:0] ldata;
  bit            rq_en[2], rq_wr[2];
  logic [AW-1:0] rq_addr[2];
  logic [DW-1:0] rq_data[2];

  task automatic model_reset();
    owner = -1; age = 0; cool = 1'b0; last = 1'b1; merr = 1'b0;
    lwr = 1'b0; laddr = '0; ldata = '0;
  endtask

  initial begin
    rst_n = 1'b0; m0_en = 0; m0_wr = 0; m1_en = 0; m1_wr = 0; mem_ack = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = rep(8'h11); m1_wdata = rep(8'h22); mem_rdata = '0;

    //           rn e0 w0 a0    e1 w1 a1    mk mb     a0 a1 en wr addr  g  b  err
    tbl[0]  = '{1, 0, 0, 'h10, 0, 0, 'h20, 0, 'h00,  0, 0, 0, 0, 'h00, 1, 0, 0};
    tbl[1]  = '{1, 1, 1, 'h10, 1, 0, 'h20, 0, 'h00,  0, 0, 0, 0, 'h00, 1, 0, 0};
    tbl[2]  = '{1, 1, 1, 'h10, 1, 0, 'h20, 0, 'h00,  0, 0, 1, 1, 'h10, 0, 1, 0};
    tbl[3]  = '{1, 1, 1, 'h10, 1, 0, 'h20, 1, 'h5A,  1, 0, 1, 1, 'h10, 0, 1, 0};
    tbl[4]  = '{1, 0, 0, 'h10, 1, 0, 'h20, 0, 'h00,  0, 0, 0, 1, 'h10, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 'h10, 1, 0, 'h20, 0, 'h00,  0, 0, 0, 1, 'h10, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 'h10, 1, 0, 'h20, 0, 'h00,  0, 0, 1, 0, 'h20, 1, 1, 0};
    tbl[7]  = '{1, 0, 0, 'h10, 1, 0, 'h20, 1, 'hC3,  0, 1, 1, 0, 'h20, 1, 1, 0};
    tbl[8]  = '{1, 1, 1, 'h10, 1, 0, 'h20, 0, 'h00,  0, 0, 0, 0, 'h20, 1, 0, 0};
    tbl[9]  = '{1, 1, 1, 'h10, 1, 0, 'h20, 0, 'h00,  0, 0, 0, 0, 'h20, 1, 0, 0};
    tbl[10] = '{1, 1, 1, 'h10, 1, 0, 'h20, 0, 'h00,  0, 0, 1, 1, 'h10, 0, 1, 0};
    tbl[11] = '{1, 1, 1, 'h10, 1, 0, 'h20, 1, 'h3C,  1, 0, 1, 1, 'h10, 0, 1, 0};
    tbl[12] = '{1, 0, 0, 'h10, 0, 0, 'h20, 0, 'h00,  0, 0, 0, 1, 'h10, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 'h10, 0, 0, 'h20, 1, 'hFF,  0, 0, 0, 1, 'h10, 0, 0, 0};
    tbl[14] = '{1, 0, 0, 'h10, 0, 0, 'h20, 0, 'h00,  0, 0, 0, 1, 'h10, 0, 0, 0};
    tbl[15] = '{1, 0, 0, 'h10, 1, 0, 'h20, 0, 'h00,  0, 0, 0, 1, 'h10, 0, 0, 0};
    tbl[16] = '{1, 0, 0, 'h10, 1, 0, 'h20, 0, 'h00,  0, 0, 1, 0, 'h20, 1, 1, 0};
    tbl[17] = '{0, 0, 0, 'h10, 1, 0, 'h20, 0, 'h00,  0, 0, 1, 0, 'h20, 1, 1, 0};
    tbl[18] = '{1, 0, 0, 'h10, 0, 0, 'h20, 1, 'h77,  0, 0, 0, 0, 'h00, 1, 0, 0};
    tbl[19] = '{1, 0, 0, 'h10, 0, 0, 'h20, 0, 'h00,  0, 0, 0, 0, 'h00, 1, 0, 0};

    do_reset();
    do_reset();

    for (int i = 0; i < 20; i++) begin
      rst_n = tbl[i].rn; m0_en = tbl[i].e0; m0_wr = tbl[i].w0; m0_addr = tbl[i].a0;
      m1_en = tbl[i].e1; m1_wr = tbl[i].w1; m1_addr = tbl[i].a1;
      mem_ack = tbl[i].mack; mem_rdata = rep(tbl[i].mb);
      @(negedge clk);
      $display("vec %0d: ack0=%b ack1=%b en=%b grant=%b busy=%b", i, d_ack0, d_ack1, d_men, d_grant, d_busy);
      chk($sformatf("vec%0d_ack0", i), d_ack0, tbl[i].x_a0);
      chk($sformatf("vec%0d_ack1", i), d_ack1, tbl[i].x_a1);
      chk($sformatf("vec%0d_data0", i), d_d0, tbl[i].x_a0 ? rep(tbl[i].mb) : '0);
      chk($sformatf("vec%0d_data1", i), d_d1, tbl[i].x_a1 ? rep(tbl[i].mb) : '0);
      chk($sformatf("vec%0d_en", i), d_men, tbl[i].x_en);
      chk($sformatf("vec%0d_wr", i), d_mwr, tbl[i].x_wr);
      chk($sformatf("vec%0d_addr", i), d_maddr, tbl[i].x_addr);
      chk($sformatf("vec%0d_grant", i), d_grant, tbl[i].x_g);
      chk($sformatf("vec%0d_busy", i), d_busy, tbl[i].x_b);
      chk($sformatf("vec%0d_err", i), d_err, tbl[i].x_err);
      next_cycle();
    end

    // Long-latency read on the default-watchdog instance: ack 10 cycles after enable.
    do_reset();
    m0_en = 1; m0_wr = 0; m0_addr = 'h400; mem_ack = 0; mem_rdata = rep(8'hA5);
    @(negedge clk);
    chk("rd_en_before_grant", l_men, 1'b0);
    next_cycle();
    for (int k = 1; k <= 11; k++) begin
      mem_ack = (k == 11);
      @(negedge clk);
      $display("rd cycle %0d: en=%b addr=%0h ack0=%b", k, l_men, l_maddr, l_ack0);
      chk("rd_en", l_men, 1'b1);
      chk("rd_wr", l_mwr, 1'b0);
      chk("rd_addr", l_maddr, 'h400);
      chk("rd_ack0", l_ack0, k == 11);
      chk("rd_ack1", l_ack1, 1'b0);
      chk("rd_data0", l_d0, (k == 11) ? rep(8'hA5) : '0);
      next_cycle();
    end
    m0_en = 0; mem_ack = 0;
    @(negedge clk);
    chk("rd_gap_en", l_men, 1'b0);
    next_cycle();

    // m1 changes its address mid-transfer; the latched address must not move.
    do_reset();
    m1_en = 1; m1_wr = 0; m1_addr = 'h100; mem_rdata = rep(8'h4B);
    next_cycle();
    m1_addr = 'h200;
    for (int k = 1; k <= 5; k++) begin
      mem_ack = (k == 5);
      @(negedge clk);
      $display("addrhold cycle %0d: addr=%0h ack1=%b", k, d_maddr, d_ack1);
      chk("hold_addr", d_maddr, 'h100);
      chk("hold_ack1", d_ack1, k == 5);
      chk("hold_ack0", d_ack0, 1'b0);
      chk("hold_data1", d_d1, (k == 5) ? rep(8'h4B) : '0);
      next_cycle();
    end
    m1_en = 0; mem_ack = 0;
    next_cycle();

    // Watchdog: never ack; abort pulse in the 9th enable cycle with zero data.
    m0_en = 1; m0_wr = 0; m0_addr = 'h40; mem_rdata = rep(8'hEE); mem_ack = 0;
    next_cycle();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      $display("wd cycle %0d: ack0=%b err=%b", k, d_ack0, d_err);
      chk("wd_ack0", d_ack0, k == 9);
      chk("wd_data0", d_d0, '0);
      chk("wd_err_early", d_err, 1'b0);
      chk("wd_en", d_men, 1'b1);
      next_cycle();
    end
    m0_en = 0;
    @(negedge clk);
    chk("wd_err_set", d_err, 1'b1);
    chk("wd_gap_en", d_men, 1'b0);
    next_cycle();
    m1_en = 1; m1_wr = 0; m1_addr = 'h80;
    next_cycle();
    @(negedge clk);
    chk("wd_next_addr", d_maddr, 'h80);
    next_cycle();
    mem_ack = 1; mem_rdata = rep(8'h3D);
    @(negedge clk);
    $display("wd recovery: ack1=%b err=%b", d_ack1, d_err);
    chk("wd_next_ack1", d_ack1, 1'b1);
    chk("wd_next_data1", d_d1, rep(8'h3D));
    chk("wd_err_sticky", d_err, 1'b1);
    next_cycle();
    m1_en = 0; mem_ack = 0;
    next_cycle();

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    rq_en[0] = 0; rq_en[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      bit rn_r, mack_r, done;
      logic [DW-1:0] md;
      rn_r = ($urandom_range(0, 199) != 0);
      for (int r = 0; r < 2; r++) begin
        if (!rq_en[r] && $urandom_range(0, 2) == 0) rq_en[r] = 1;
        rq_wr[r] = 1'($urandom_range(0, 1));
        rq_addr[r] = $urandom();
        rq_data[r] = rnd256();
      end
      mack_r = (owner >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      md = rnd256();
      rst_n = rn_r; mem_ack = mack_r; mem_rdata = md;
      m0_en = rq_en[0]; m0_wr = rq_wr[0]; m0_addr = rq_addr[0]; m0_wdata = rq_data[0];
      m1_en = rq_en[1]; m1_wr = rq_wr[1]; m1_addr = rq_addr[1]; m1_wdata = rq_data[1];
      done = (owner >= 0) && (mack_r || age == TO);
      @(negedge clk);
      $display("rnd %0d: rst_n=%b req=%b%b mack=%b ack=%b%b grant=%b err=%b", n, rn_r,
               rq_en[1], rq_en[0], mack_r, d_ack1, d_ack0, d_grant, d_err);
      chk("rnd_ack0", d_ack0, done && owner == 0);
      chk("rnd_ack1", d_ack1, done && owner == 1);
      chk("rnd_data0", d_d0, (done && owner == 0 && mack_r) ? md : '0);
      chk("rnd_data1", d_d1, (done && owner == 1 && mack_r) ? md : '0);
      chk("rnd_en", d_men, owner >= 0);
      chk("rnd_busy", d_busy, owner >= 0);
      chk("rnd_wr", d_mwr, lwr);
      chk("rnd_addr", d_maddr, laddr);
      chk("rnd_wdata", d_mdata, ldata);
      chk("rnd_grant", d_grant, last);
      chk("rnd_err", d_err, merr);
      if (!rn_r) begin
        model_reset();
        rq_en[0] = 0; rq_en[1] = 0;
      end else if (owner >= 0) begin
        if (done) begin
          if (!mack_r) merr = 1;
          rq_en[owner] = 0;
          owner = -1;
          cool = 1;
        end else begin
          age++;
        end
      end else if (cool) begin
        cool = 0;
      end else if (rq_en[0] || rq_en[1]) begin
        pick = (rq_en[0] && rq_en[1]) ? (last ? 0 : 1) : (rq_en[1] ? 1 : 0);
        owner = pick; last = (pick == 1); age = 0;
        lwr = rq_wr[pick]; laddr = rq_addr[pick]; ldata = rq_data[pick];
      end
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
